// File: rtl/flux_acq_engine.sv
// rtl/flux_acq_engine.sv - flux-transition interval acquisition engine
// Purpose: times CLKEN-qualified intervals between read-data pulses and emits one
//          {index_flag, timer} record per transition or timer overflow.
// Ports:
//    CLOCK, RESET_N        clock, synchronous active-low reset
//    CLKEN                 timer count enable
//    RUN, WAIT_INDEX       start/abort control, index-aligned start select
//    STOP_REVS             revolutions to capture (0 = unlimited)
//    RAM_FULL              acquisition RAM full, ends capture
//    FD_RDDATA_IN          raw read-data pulse (asynchronous)
//    FD_INDEX_IN           raw index pulse (asynchronous)
//    DATA, WRITE           record and its one-cycle write strobe
//    BUSY, DONE            capture in progress / capture finished
//    REV_COUNT             index edges seen during capture
module flux_acq_engine #(
   parameter int TIMER_BITS = 7,
   parameter int REV_BITS   = 8
) (
   input  logic                  CLOCK,
   input  logic                  RESET_N,
   input  logic                  CLKEN,
   input  logic                  RUN,
   input  logic                  WAIT_INDEX,
   input  logic [REV_BITS-1:0]   STOP_REVS,
   input  logic                  RAM_FULL,
   input  logic                  FD_RDDATA_IN,
   input  logic                  FD_INDEX_IN,
   output logic [TIMER_BITS:0]   DATA,
   output logic                  WRITE,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [REV_BITS-1:0]   REV_COUNT
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAITIDX = 2'd1,
      ST_ACQ     = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [TIMER_BITS-1:0] TIMER_ONE = {{(TIMER_BITS-1){1'b0}}, 1'b1};
   localparam logic [TIMER_BITS-1:0] TIMER_MAX = {TIMER_BITS{1'b1}};
   localparam logic [REV_BITS-1:0]   REV_ONE   = {{(REV_BITS-1){1'b0}}, 1'b1};
   localparam logic [REV_BITS-1:0]   REV_MAX   = {REV_BITS{1'b1}};

   state_t                 state, state_n;
   logic [TIMER_BITS-1:0]  timer, timer_n;
   logic                   index_flag, index_flag_n;
   logic [TIMER_BITS:0]    data_n;
   logic                   write_n;
   logic [REV_BITS-1:0]    rev_n;

   // Two metastability flops followed by one history flop per input.
   logic [2:0]             rd_sync, idx_sync;
   logic                   rd_event, idx_event;
   logic                   flag_merged;

   assign rd_event  = rd_sync[1]  & ~rd_sync[2];
   assign idx_event = idx_sync[1] & ~idx_sync[2];

   assign BUSY = (state == ST_WAITIDX) || (state == ST_ACQ);
   assign DONE = (state == ST_DONE);

   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         state      <= ST_IDLE;
         timer      <= TIMER_ONE;
         index_flag <= 1'b0;
         DATA       <= '0;
         WRITE      <= 1'b0;
         REV_COUNT  <= '0;
         rd_sync    <= '0;
         idx_sync   <= '0;
      end else begin
         state      <= state_n;
         timer      <= timer_n;
         index_flag <= index_flag_n;
         DATA       <= data_n;
         WRITE      <= write_n;
         REV_COUNT  <= rev_n;
         rd_sync    <= {rd_sync[1:0], FD_RDDATA_IN};
         idx_sync   <= {idx_sync[1:0], FD_INDEX_IN};
      end
   end

   always_comb begin
      state_n      = state;
      timer_n      = timer;
      index_flag_n = index_flag;
      data_n       = DATA;
      write_n      = 1'b0;
      rev_n        = REV_COUNT;
      // An index edge landing in a write cycle is folded into that record.
      flag_merged  = index_flag | idx_event;

      if (!RUN) begin
         state_n      = ST_IDLE;
         timer_n      = TIMER_ONE;
         index_flag_n = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               timer_n      = TIMER_ONE;
               index_flag_n = 1'b0;
               rev_n        = '0;
               state_n      = WAIT_INDEX ? ST_WAITIDX : ST_ACQ;
            end
            ST_WAITIDX: begin
               // The aligning index edge only starts capture; it is not a revolution.
               timer_n = TIMER_ONE;
               if (idx_event)
                  state_n = ST_ACQ;
            end
            ST_ACQ: begin
               if (RAM_FULL) begin
                  state_n = ST_DONE;
               end else begin
                  if (idx_event) begin
                     if (REV_COUNT != REV_MAX)
                        rev_n = REV_COUNT + REV_ONE;
                     if ((STOP_REVS != '0) && (rev_n == STOP_REVS))
                        state_n = ST_DONE;
                  end
                  // A transition coinciding with overflow carries the max count.
                  if (rd_event) begin
                     data_n       = {flag_merged, timer};
                     write_n      = 1'b1;
                     timer_n      = TIMER_ONE;
                     index_flag_n = 1'b0;
                  end else if (CLKEN && (timer == TIMER_MAX)) begin
                     data_n       = {flag_merged, {TIMER_BITS{1'b0}}};
                     write_n      = 1'b1;
                     timer_n      = TIMER_ONE;
                     index_flag_n = 1'b0;
                  end else begin
                     timer_n      = timer + {{(TIMER_BITS-1){1'b0}}, CLKEN};
                     index_flag_n = flag_merged;
                  end
               end
            end
            ST_DONE: begin
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

endmodule
